ssram_2p_pipe: RTL and testbench
================================

Name: ssram_2p_pipe

Overview:
Parametrised simple-dual-port synchronous SRAM: one write port and one read port, each with its own valid/ready request handshake, plus byte enables on writes. Read latency is configurable, and same-word read/write collisions are resolved by a selectable policy. An internal init FSM zero-clears the whole array after reset. It is the drop-in data/instruction memory for core configurations that need concurrent fetch and store.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8, with WIDTH/8 a power of two.
ADDR_BITS, 16, word-index bits; depth = 1<<ADDR_BITS words.
READ_LATENCY, 1, cycles from read accept to rd_rsp_valid; legal values 1 or 2.
BYPASS, 1, collision policy: 1 = write-first (forward new bytes), 0 = read-first (old data).

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request valid
wr_ready  out  1  write port can accept
wr_addr  in  32  byte address
wr_data  in  WIDTH  write data
wr_be  in  WIDTH/8  byte enables; bit b covers data[8b+7:8b]
rd_valid  in  1  read request valid
rd_ready  out  1  read port can accept
rd_addr  in  32  byte address
rd_rsp_valid  out  1  one-cycle pulse: rd_data/rd_err valid
rd_data  out  WIDTH  read data
rd_err  out  1  response was out of range
init_done  out  1  high once the array clear is finished

Behaviour:
- Clock is clk. Reset is rst: one clock domain; reset is synchronous and active-high.
- Word index = addr[ADDR_BITS+LB-1:LB], where LB = log2(WIDTH/8). Low LB bits are ignored. The address is out of range when any bit above the index is 1.
- FSM states: INIT and RUN.
  - rst forces INIT with the clear counter at 0.
  - INIT writes zero to word[counter] each cycle, then increments the counter. After word (1<<ADDR_BITS)-1 it moves to RUN.
  - The clear takes exactly 1<<ADDR_BITS cycles after rst deasserts.
- In INIT: wr_ready=0, rd_ready=0, init_done=0. In RUN: wr_ready=1, rd_ready=1, init_done=1.
- Reset values: rd_rsp_valid=0, rd_data=0, rd_err=0, init_done=0, wr_ready=0, rd_ready=0. All read-pipeline valid bits are cleared.
- Write accept (wr_valid & wr_ready):
  - Bytes with wr_be[b]=1 are updated at the clock edge.
  - wr_be=0 makes the write a no-op.
  - An out-of-range write is dropped silently.
- Read accept (rd_valid & rd_ready):
  - The response appears exactly READ_LATENCY cycles later: rd_rsp_valid=1 for one cycle, with rd_data and rd_err.
  - The response path has no backpressure. Back-to-back reads give back-to-back responses at full throughput.
  - An out-of-range read returns rd_data=0 and rd_err=1.
  - rd_data and rd_err hold their value between responses.
- READ_LATENCY=2 adds one output register stage after the array read. rd_data must be identical for both latency settings, apart from timing.
- Collision (read and write accepted in the same cycle to the same in-range word):
  - BYPASS=1: the response carries new bytes where wr_be=1 and old bytes elsewhere.
  - BYPASS=0: the response carries the pre-write word.
  - The memory ends with the write applied in both cases.
- Reads after a write:
  - A read accepted the cycle after a write to the same word sees the new data, under both policies.
  - Requests presented while ready=0 are ignored and not queued.
- rst asserted mid-operation:
  - In-flight read responses are discarded; no rd_rsp_valid occurs.
  - The FSM re-enters INIT and the array is re-cleared.
  - A write accepted in the same cycle that rst is high is not performed.

Test Plan:
- ADDR_BITS=4: deassert rst at cycle 0 -> init_done rises after exactly 16 cycles. Reading all 16 words then returns 0 with rd_err=0.
- Write 0xDEADBEEF to byte addr 0x8 with be=4'b1111. Then write 0x000000AA with be=4'b0001. Read 0x8 (also 0xB) -> 0xDEADBEAA, returned 1 cycle after accept (READ_LATENCY=1) or 2 cycles after (READ_LATENCY=2).
- Same-cycle write 0x11223344 (be=4'b1100) and read to a word holding 0xAABBCCDD -> BYPASS=1 returns 0x1122CCDD; BYPASS=0 returns 0xAABBCCDD. A following read returns 0x1122CCDD in both cases.
- Read addr 0x00010000 with ADDR_BITS=4 -> rd_err=1, rd_data=0. Write to the same out-of-range address, then read word 0 -> unchanged.
- Issue 8 consecutive reads of distinct words -> 8 consecutive rd_rsp_valid pulses, in order, with correct data.
- Accept a read, then assert rst on the next cycle -> no rd_rsp_valid, rd_data=0. Memory is re-cleared and init_done returns after 16 cycles.

Source files
------------

// File: rtl/ssram_2p_pipe.sv
// Simple-dual-port synchronous SRAM with byte-enable writes, 1- or 2-cycle read
// latency, a selectable same-word collision policy and a zero-clear pass after reset.
module ssram_2p_pipe #(
  parameter int WIDTH        = 32,
  parameter int ADDR_BITS    = 16,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [31:0]        rd_addr,
  output logic               rd_rsp_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_err,
  output logic               init_done
);

  localparam int NB    = WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int HI    = ADDR_BITS + LB;

  typedef enum logic {INIT, RUN} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] cnt_reg, cnt_next;
  logic                 run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_BITS{1'b1}}) state_next = RUN;
      end
      default: ;
    endcase
  end

  assign run       = (state_reg == RUN);
  assign wr_ready  = run;
  assign rd_ready  = run;
  assign init_done = run;

  // Word index comes from the bits above the byte offset; anything set above it is out of range.
  logic [ADDR_BITS-1:0] wr_idx, rd_idx;
  logic                 wr_oor, rd_oor;
  logic                 unused_addr_bits;

  assign wr_idx = wr_addr[HI-1:LB];
  assign rd_idx = rd_addr[HI-1:LB];
  assign wr_oor = |(wr_addr >> HI);
  assign rd_oor = |(rd_addr >> HI);
  assign unused_addr_bits = ^{wr_addr, rd_addr};

  logic wr_acc, rd_acc;
  assign wr_acc = wr_valid & run & ~rst & ~wr_oor;
  assign rd_acc = rd_valid & run & ~rst;

  // The clear pass and the write port share one array write port.
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [WIDTH-1:0]     mem_wdata;
  logic [NB-1:0]        mem_be;

  assign mem_we    = ~rst & ((state_reg == INIT) | wr_acc);
  assign mem_idx   = run ? wr_idx  : cnt_reg;
  assign mem_wdata = run ? wr_data : '0;
  assign mem_be    = run ? wr_be   : '1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_reg;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (rd_acc) ram_reg <= mem[rd_idx];
  end

  // Stage-1 side state travels with the array read so a collision can be patched afterwards.
  logic             v1_reg, zero_reg, err_reg, coll_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [NB-1:0]    wbe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      zero_reg <= 1'b1;
      err_reg  <= 1'b0;
      coll_reg <= 1'b0;
    end else begin
      v1_reg <= rd_acc;
      if (rd_acc) begin
        zero_reg  <= rd_oor;
        err_reg   <= rd_oor;
        coll_reg  <= wr_acc && (wr_idx == rd_idx) && !rd_oor;
        wdata_reg <= wr_data;
        wbe_reg   <= wr_be;
      end
    end
  end

  logic [WIDTH-1:0] lane_word, rd_word;
  logic             fwd;

  assign fwd = (BYPASS != 0) && coll_reg;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign lane_word[8*gi +: 8] = (fwd && wbe_reg[gi]) ? wdata_reg[8*gi +: 8] : ram_reg[8*gi +: 8];
  end

  assign rd_word = zero_reg ? '0 : lane_word;

  // A response landing in a reset cycle is suppressed; later ones are flushed by the reset.
  if (READ_LATENCY == 2) begin : g_lat2
    logic             out_valid_reg, out_err_reg;
    logic [WIDTH-1:0] out_data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
        out_err_reg   <= 1'b0;
      end else begin
        out_valid_reg <= v1_reg;
        if (v1_reg) begin
          out_data_reg <= rd_word;
          out_err_reg  <= err_reg;
        end
      end
    end

    assign rd_rsp_valid = out_valid_reg & ~rst;
    assign rd_data      = out_data_reg;
    assign rd_err       = out_err_reg;
  end else begin : g_lat1
    assign rd_rsp_valid = v1_reg & ~rst;
    assign rd_data      = rd_word;
    assign rd_err       = err_reg;
  end

endmodule

// File: tb/tb_ssram_2p_pipe.sv
// Bench for ssram_2p_pipe: two instances (latency 1 write-first, latency 2 read-first)
// share one stimulus stream and are checked cycle by cycle against a word-array model.
module tb_ssram_2p_pipe;

  logic        clk = 1'b0;
  logic        rst, wr_valid, rd_valid;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_be;

  logic        a_wr_ready, a_rd_ready, a_valid, a_err, a_init;
  logic [31:0] a_data;
  logic        b_wr_ready, b_rd_ready, b_valid, b_err, b_init;
  logic [31:0] b_data;

  always #5 clk = ~clk;

  ssram_2p_pipe #(.WIDTH(32), .ADDR_BITS(4), .READ_LATENCY(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(a_rd_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(a_valid), .rd_data(a_data), .rd_err(a_err), .init_done(a_init)
  );

  ssram_2p_pipe #(.WIDTH(32), .ADDR_BITS(4), .READ_LATENCY(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
    .rd_rsp_valid(b_valid), .rd_data(b_data), .rd_err(b_err), .init_done(b_init)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        rv;
    logic [31:0] ra;
    logic [31:0] e1;
    logic [31:0] e0;
    logic        err;
  } vec_t;

  rsp_t        qa[$], qb[$];
  logic [31:0] mem_m [16];
  bit          run_m, ready_cur, rst_cur, prev_rst, started, use_table;
  int          clr_m, cyc, vectors, miscompares;
  logic [31:0] last_da, last_db, tbl_e1, tbl_e0;
  logic        last_ea, last_eb, tbl_err;
  vec_t        tbl [14];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_rsp(input string nm, input logic v, input logic [31:0] d, input logic e,
                           input bit ev, input rsp_t r,
                           inout logic [31:0] last_d, inout logic last_e);
    chk({nm, ".valid"}, {31'b0, v}, {31'b0, ev});
    if (!rst_cur) begin
      if (ev) begin
        last_d = r.data;
        last_e = r.err;
        $display("rsp %s cyc=%0d data=%h err=%0b", nm, cyc, d, e);
      end
      chk({nm, ".data"}, d, last_d);
      chk({nm, ".err"}, {31'b0, e}, {31'b0, last_e});
    end
  endtask

  task automatic check_cycle();
    bit   ev;
    rsp_t r;
    chk("a.init_done", {31'b0, a_init}, {31'b0, ready_cur});
    chk("b.init_done", {31'b0, b_init}, {31'b0, ready_cur});
    chk("a.ready", {30'b0, a_wr_ready, a_rd_ready}, {30'b0, ready_cur, ready_cur});
    chk("b.ready", {30'b0, b_wr_ready, b_rd_ready}, {30'b0, ready_cur, ready_cur});
    r  = '{0, 32'h0, 1'b0};
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    if (ev) r = qa.pop_front();
    check_rsp("a", a_valid, a_data, a_err, ev, r, last_da, last_ea);
    r  = '{0, 32'h0, 1'b0};
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    if (ev) r = qb.pop_front();
    check_rsp("b", b_valid, b_data, b_err, ev, r, last_db, last_eb);
  endtask

  // Present one cycle of inputs, advance the model across the coming edge, check, then move on.
  task automatic step(input logic r, input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic rv, input logic [31:0] ra);
    logic [31:0] e1, e0, old;
    logic        err, woor, roor;
    rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be; rd_valid = rv; rd_addr = ra;
    if (prev_rst) begin
      last_da = '0; last_db = '0; last_ea = 1'b0; last_eb = 1'b0;
    end
    rst_cur   = r;
    ready_cur = run_m;
    woor = (wa >= 32'd64);
    roor = (ra >= 32'd64);
    if (r) begin
      qa.delete();
      qb.delete();
      run_m = 1'b0;
      clr_m = 0;
    end else if (!run_m) begin
      mem_m[clr_m] = '0;
      clr_m++;
      if (clr_m == 16) run_m = 1'b1;
    end else begin
      if (rv) begin
        if (use_table) begin
          e1 = tbl_e1; e0 = tbl_e0; err = tbl_err;
        end else if (roor) begin
          e1 = '0; e0 = '0; err = 1'b1;
        end else begin
          old = mem_m[ra[5:2]];
          e0  = old;
          e1  = (wv && !woor && wa[5:2] == ra[5:2]) ? merge(old, wd, be) : old;
          err = 1'b0;
        end
        qa.push_back('{cyc + 1, e1, err});
        qb.push_back('{cyc + 2, e0, err});
      end
      if (wv && !woor) mem_m[wa[5:2]] = merge(mem_m[wa[5:2]], wd, be);
    end
    @(negedge clk);
    if (started) check_cycle();
    prev_rst = r;
    @(posedge clk);
    #1;
    cyc++;
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; clr_m = 0;
    run_m = 1'b0; started = 1'b0; prev_rst = 1'b0; use_table = 1'b0;
    last_da = '0; last_db = '0; last_ea = 1'b0; last_eb = 1'b0;
    tbl_e1 = '0; tbl_e0 = '0; tbl_err = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'hFFFF_FFFF;

    //            wv  wa             wd             be     rv  ra             e1 (write-first) e0 (read-first) err
    tbl[0]  = '{1'b1, 32'h8,         32'hDEADBEEF, 4'hF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b1, 32'h8,         32'h000000AA, 4'h1, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[2]  = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'h8,         32'hDEADBEAA,  32'hDEADBEAA,  1'b0};
    tbl[3]  = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'hB,         32'hDEADBEAA,  32'hDEADBEAA,  1'b0};
    tbl[4]  = '{1'b1, 32'h10,        32'hAABBCCDD, 4'hF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[5]  = '{1'b1, 32'h10,        32'h11223344, 4'hC, 1'b1, 32'h10,        32'h1122CCDD,  32'hAABBCCDD,  1'b0};
    tbl[6]  = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'h10,        32'h1122CCDD,  32'h1122CCDD,  1'b0};
    tbl[7]  = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'h0001_0000, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[9]  = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[10] = '{1'b1, 32'h4,         32'h12345678, 4'h0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[11] = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'h4,         32'h0,         32'h0,         1'b0};
    tbl[12] = '{1'b1, 32'hC,         32'h12345566, 4'h2, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[13] = '{1'b0, 32'h0,         32'h0,        4'h0, 1'b1, 32'hC,         32'h00005500,  32'h00005500,  1'b0};

    rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    cyc = 1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    // Clear pass: requests during INIT must be ignored; init_done checked every cycle.
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'(i * 4));
    idle(2);

    use_table = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tbl_e1 = tbl[i].e1; tbl_e0 = tbl[i].e0; tbl_err = tbl[i].err;
      step(1'b0, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rv, tbl[i].ra);
    end
    use_table = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'(32 + i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'(i * 4 + 32 * (i % 2)));
    idle(3);

    // Read in flight when reset hits, plus a write in the reset cycle itself.
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8);
    step(1'b1, 1'b1, 32'h8, 32'h77777777, 4'hF, 1'b1, 32'h8);
    idle(19);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic        r, wv, rv;
      logic [31:0] wa, ra, wd;
      logic [3:0]  be;
      r  = ($urandom_range(0, 99) == 0);
      wv = $urandom_range(0, 1) != 0;
      rv = $urandom_range(0, 1) != 0;
      wa = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      ra = ($urandom_range(0, 2) == 0) ? wa :
           (($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      step(r, wv, wa, wd, be, rv, ra);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
